// File: rtl/mv_ch_scheduler.sv
// Multi-channel moving-average scheduler: one shared window RAM and accumulator, time-multiplexed round-robin over NCH channels.
// Latency: 3 cycles from grant (IDLE) to dout_valid; each serviced sample occupies a 3-cycle slot (IDLE, READ, UPDATE).
// Backpressure: none; a strobe on a channel that is still pending is dropped and raises that channel's sticky overrun flag.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   trig[NCH]         per-channel 1-cycle sample strobe
//   din[32*NCH]       signed samples, channel k at [32k+31:32k]
//   clear             1-cycle request to re-zero window RAM, sums and indices
//   overrun_clr       clears sticky overrun flags (a same-cycle new overrun wins)
//   busy              high while the RAM clear sweep runs; strobes ignored
//   dout, dout_ch     signed window average and its channel
//   dout_valid        1-cycle result strobe
//   overrun[NCH]      sticky: strobe arrived while the channel was still pending
module mv_ch_scheduler #(
  parameter int NCH      = 4,
  parameter int WIN_LOG2 = 13,
  parameter int CHW      = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       trig,
  input  logic [32*NCH-1:0]    din,
  input  logic                 clear,
  input  logic                 overrun_clr,
  output logic                 busy,
  output logic [31:0]          dout,
  output logic [CHW-1:0]       dout_ch,
  output logic                 dout_valid,
  output logic [NCH-1:0]       overrun
);

  localparam int AW    = CHW + WIN_LOG2;
  localparam int DEPTH = NCH << WIN_LOG2;
  localparam int SW    = 32 + WIN_LOG2;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_READ,
    S_UPDATE
  } state_t;

  state_t                state_q, state_d;

  logic [AW-1:0]         clr_addr_q;
  logic [NCH-1:0]        pending_q;
  logic [31:0]           hold_q [NCH];
  logic [31:0]           work_q;
  logic signed [SW-1:0]  sum_q [NCH];
  logic [WIN_LOG2-1:0]   idx_q [NCH];
  logic [CHW-1:0]        rr_ptr_q;
  logic [CHW-1:0]        cur_ch_q;
  logic [AW-1:0]         rd_addr_q;
  logic [31:0]           rd_data_q;

  logic [31:0]           ram [DEPTH];

  // Combinational control
  logic                  any_pend;
  logic [CHW-1:0]        grant_c;
  logic [CHW-1:0]        cand;
  logic                  do_grant;
  logic                  do_upd;
  logic                  capture_en;
  logic [NCH-1:0]        ovr_set;
  logic                  ram_we;
  logic [AW-1:0]         ram_wa;
  logic [31:0]           ram_wd;
  logic signed [SW-1:0]  old_ext;
  logic signed [SW-1:0]  work_ext;
  logic signed [SW-1:0]  s_new;

  assign busy = (state_q == S_CLEAR);

  // Round-robin search: first pending channel starting at rr_ptr.
  always_comb begin
    any_pend = 1'b0;
    grant_c  = '0;
    cand     = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = rr_ptr_q + CHW'(i);
      if (!any_pend && pending_q[cand]) begin
        any_pend = 1'b1;
        grant_c  = cand;
      end
    end
  end

  assign do_grant   = (state_q == S_IDLE) && any_pend && !clear;
  assign do_upd     = (state_q == S_UPDATE) && !clear;
  assign capture_en = !busy && !clear;

  // A strobe on a still-pending channel is an overrun unless that channel is
  // being granted this very cycle (then the new sample simply replaces hold).
  always_comb begin
    ovr_set = '0;
    for (int k = 0; k < NCH; k++) begin
      if (capture_en && trig[k] && pending_q[k] &&
          !(do_grant && (grant_c == CHW'(k)))) begin
        ovr_set[k] = 1'b1;
      end
    end
  end

  // Running sum including the current sample: drop the oldest, add the newest.
  assign old_ext  = {{WIN_LOG2{rd_data_q[31]}}, rd_data_q};
  assign work_ext = {{WIN_LOG2{work_q[31]}}, work_q};
  assign s_new    = sum_q[cur_ch_q] - old_ext + work_ext;

  // FSM next state and RAM write port
  always_comb begin
    state_d = state_q;
    ram_we  = 1'b0;
    ram_wa  = '0;
    ram_wd  = '0;
    case (state_q)
      S_CLEAR: begin
        ram_we = 1'b1;
        ram_wa = clr_addr_q;
        if (clr_addr_q == {AW{1'b1}}) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (any_pend) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        ram_we  = 1'b1;
        ram_wa  = rd_addr_q;
        ram_wd  = work_q;
        state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
    // A clear request abandons whatever is in flight and restarts the sweep.
    if (clear) begin
      state_d = S_CLEAR;
      ram_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Window RAM: one write port, registered read issued in READ.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_wa] <= ram_wd;
    end
    if (state_q == S_READ) begin
      rd_data_q <= ram[rd_addr_q];
    end
  end

  // Datapath and bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_addr_q <= '0;
      pending_q  <= '0;
      work_q     <= '0;
      rr_ptr_q   <= '0;
      cur_ch_q   <= '0;
      rd_addr_q  <= '0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      overrun    <= '0;
      for (int k = 0; k < NCH; k++) begin
        hold_q[k] <= '0;
        sum_q[k]  <= '0;
        idx_q[k]  <= '0;
      end
    end else begin
      dout_valid <= 1'b0;
      overrun    <= (overrun & ~{NCH{overrun_clr}}) | ovr_set;

      if (clear || (state_q == S_CLEAR)) begin
        clr_addr_q <= clear ? '0 : clr_addr_q + AW'(1);
        pending_q  <= '0;
        for (int k = 0; k < NCH; k++) begin
          sum_q[k] <= '0;
          idx_q[k] <= '0;
        end
      end else begin
        if (do_grant) begin
          rr_ptr_q           <= grant_c + CHW'(1);
          pending_q[grant_c] <= 1'b0;
          work_q             <= hold_q[grant_c];
          cur_ch_q           <= grant_c;
          rd_addr_q          <= {grant_c, idx_q[grant_c]};
        end

        // Capture comes after the grant so a same-cycle re-strobe of the
        // granted channel keeps it pending with the fresh sample.
        for (int k = 0; k < NCH; k++) begin
          if (trig[k]) begin
            if (!pending_q[k]) begin
              pending_q[k] <= 1'b1;
              hold_q[k]    <= din[32*k +: 32];
            end else if (do_grant && (grant_c == CHW'(k))) begin
              pending_q[k] <= 1'b1;
              hold_q[k]    <= din[32*k +: 32];
            end
          end
        end

        if (do_upd) begin
          sum_q[cur_ch_q] <= s_new;
          idx_q[cur_ch_q] <= idx_q[cur_ch_q] + WIN_LOG2'(1);
          // Bits above the shifted window are pure sign extension, so this
          // slice equals (s_new >>> WIN_LOG2)[31:0].
          dout            <= s_new[WIN_LOG2 +: 32];
          dout_ch         <= cur_ch_q;
          dout_valid      <= 1'b1;
        end
      end
    end
  end

endmodule
